// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer between the PPU pixel stream and display scan-out.
// Define PPU_LB_PALETTE_EN to map pixels through bgp at write time; otherwise raw indices are stored.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for DRAW to open a new line
// S_FILL   | accepting pixels into bank[wr_bank]
// S_WAIT_END | line closed, waiting for DRAW to end
// S_VBL    | vertical blank, line counter held at 0
module ppu_line_buffer #(
    parameter int LINE_W = 160,
    parameter int LINES  = 144
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] px_in,
    input  logic       px_valid,
    input  logic [1:0] ppu_mode,
    input  logic [7:0] bgp,
    input  logic       rd_en,
    input  logic [7:0] rd_x,
    output logic [1:0] rd_shade,
    output logic       line_ready,
    output logic [7:0] line_num,
    input  logic       line_ack,
    output logic       frame_start,
    output logic       overrun,
    input  logic       clr_overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_END,
        S_VBL
    } state_t;

    localparam logic [1:0] M_VBLANK = 2'd1;
    localparam logic [1:0] M_SCAN   = 2'd2;
    localparam logic [1:0] M_DRAW   = 2'd3;

    localparam logic [7:0] LINE_W_C  = 8'(LINE_W);
    localparam logic [7:0] LAST_LINE = 8'(LINES - 1);

    state_t     state_q, state_d;
    logic       wr_bank;
    logic [7:0] wr_x;
    logic [7:0] wr_line;
    logic [7:0] line_len [2];
    logic [1:0] mem [2][LINE_W];

    logic       do_write, do_close, do_swap, start_line, frame_pulse;
    logic [1:0] wr_shade;
    logic       rd_bank;
    logic       rd_hit;

`ifdef PPU_LB_PALETTE_EN
    assign wr_shade = bgp[{px_in, 1'b0} +: 2];
`else
    logic unused_bgp;
    assign unused_bgp = ^bgp;
    assign wr_shade   = px_in;
`endif

    assign rd_bank = ~wr_bank;
    assign rd_hit  = line_ready && (rd_x < line_len[rd_bank]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // V_BLANK overrides every state, so an open line is dropped without a close.
    always_comb begin
        state_d     = state_q;
        do_write    = 1'b0;
        do_close    = 1'b0;
        do_swap     = 1'b0;
        start_line  = 1'b0;
        frame_pulse = 1'b0;
        if (ppu_mode == M_VBLANK) begin
            state_d = S_VBL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ppu_mode == M_DRAW) begin
                        state_d    = S_FILL;
                        start_line = 1'b1;
                    end
                end
                S_FILL: begin
                    if (ppu_mode != M_DRAW || wr_x == LINE_W_C) begin
                        do_close = 1'b1;
                        do_swap  = !line_ready || line_ack;
                        state_d  = S_WAIT_END;
                    end else if (px_valid) begin
                        do_write = 1'b1;
                    end
                end
                S_WAIT_END: begin
                    if (ppu_mode != M_DRAW) state_d = S_IDLE;
                end
                S_VBL: begin
                    if (ppu_mode == M_SCAN) begin
                        state_d     = S_IDLE;
                        frame_pulse = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_bank][wr_x] <= wr_shade;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank     <= 1'b0;
            wr_x        <= 8'd0;
            wr_line     <= 8'd0;
            line_len[0] <= 8'd0;
            line_len[1] <= 8'd0;
            line_ready  <= 1'b0;
            line_num    <= 8'd0;
            overrun     <= 1'b0;
            frame_start <= 1'b0;
            rd_shade    <= 2'd0;
        end else begin
            frame_start <= frame_pulse;

            if (start_line)    wr_x <= 8'd0;
            else if (do_write) wr_x <= wr_x + 8'd1;

            if (do_close) line_len[wr_bank] <= wr_x;

            if (ppu_mode == M_VBLANK)    wr_line <= 8'd0;
            else if (do_close)           wr_line <= (wr_line == LAST_LINE) ? 8'd0 : wr_line + 8'd1;

            // A swap in the same cycle as an ack keeps the buffer ready with the new line.
            if (do_swap) begin
                wr_bank    <= ~wr_bank;
                line_ready <= 1'b1;
                line_num   <= wr_line;
            end else if (line_ack) begin
                line_ready <= 1'b0;
            end

            if (do_close && !do_swap) overrun <= 1'b1;
            else if (clr_overrun)     overrun <= 1'b0;

            if (rd_en) rd_shade <= rd_hit ? mem[rd_bank][rd_x] : 2'd0;
        end
    end

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Scoreboarded bench for ppu_line_buffer: reads push expected shades, a monitor checks rd_shade.
module tb_ppu_line_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] px_in = 2'd0;
    logic       px_valid = 1'b0;
    logic [1:0] ppu_mode = 2'd0;
    logic [7:0] bgp = 8'hE4;
    logic       rd_en = 1'b0;
    logic [7:0] rd_x = 8'd0;
    logic [1:0] rd_shade;
    logic       line_ready;
    logic [7:0] line_num;
    logic       line_ack = 1'b0;
    logic       frame_start;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    localparam logic [1:0] M_HBLANK = 2'd0;
    localparam logic [1:0] M_VBLANK = 2'd1;
    localparam logic [1:0] M_SCAN   = 2'd2;
    localparam logic [1:0] M_DRAW   = 2'd3;

`ifdef PPU_LB_PALETTE_EN
    localparam bit PAL = 1'b1;
`else
    localparam bit PAL = 1'b0;
`endif

    ppu_line_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .px_in       (px_in),
        .px_valid    (px_valid),
        .ppu_mode    (ppu_mode),
        .bgp         (bgp),
        .rd_en       (rd_en),
        .rd_x        (rd_x),
        .rd_shade    (rd_shade),
        .line_ready  (line_ready),
        .line_num    (line_num),
        .line_ack    (line_ack),
        .frame_start (frame_start),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read captured at a posedge is checked against the scoreboard at the next negedge.
    initial begin
        logic pend;
        forever begin
            @(posedge clk);
            pend = rd_en && rst;
            @(negedge clk);
            if (pend) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_shade: got %0d with no expected entry", rd_shade);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(rd_shade) != e) begin
                        failures++;
                        $display("FAIL rd_shade: got %0d expected %0d", rd_shade, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input int x, input int exp);
        rd_en = 1'b1;
        rd_x  = 8'(x);
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic ack_pulse();
        line_ack = 1'b1;
        tick();
        line_ack = 1'b0;
    endtask

    // Pixel i carries index base + step*i (mod 4).
    task automatic fill_line(input int n, input int base, input int step, input bit ack_close);
        ppu_mode = M_DRAW;
        tick();
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            px_in    = 2'(base + step * i);
            tick();
        end
        px_valid = 1'b0;
        ppu_mode = M_HBLANK;
        line_ack = ack_close;
        tick();
        line_ack = 1'b0;
        tick();
    endtask

    initial begin
        #7;
        chk("reset rd_shade", int'(rd_shade), 0);
        chk("reset line_ready", int'(line_ready), 0);
        chk("reset line_num", int'(line_num), 0);
        chk("reset frame_start", int'(frame_start), 0);
        chk("reset overrun", int'(overrun), 0);
        tick();
        rst = 1'b1;
        tick();

        // Full line, identity palette
        bgp = 8'hE4;
        fill_line(160, 0, 1, 1'b0);
        chk("full line_ready", int'(line_ready), 1);
        chk("full line_num", int'(line_num), 0);
        chk("full overrun", int'(overrun), 0);
        rd(0, 0); rd(1, 1); rd(2, 2); rd(3, 3);
        rd(159, 3);
        rd(160, 0);

        ack_pulse();
        chk("ack clears ready", int'(line_ready), 0);
        rd(0, 0);

        // Short line with palette 0x1B; index at x is (3+x)%4
        bgp = 8'h1B;
        fill_line(100, 3, 1, 1'b0);
        chk("short line_ready", int'(line_ready), 1);
        chk("short line_num", int'(line_num), 1);
        rd(5, PAL ? 3 : 0);
        rd(99, PAL ? 1 : 2);
        rd(100, 0);
        rd(120, 0);

        // Overrun
        bgp = 8'hE4;
        ack_pulse();
        fill_line(20, 1, 0, 1'b0);
        chk("lineA line_num", int'(line_num), 2);
        chk("lineA overrun", int'(overrun), 0);
        fill_line(20, 2, 0, 1'b0);
        chk("lineB overrun", int'(overrun), 1);
        chk("lineB line_num held", int'(line_num), 2);
        chk("lineB ready held", int'(line_ready), 1);
        rd(0, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_overrun", int'(overrun), 0);
        fill_line(10, 3, 0, 1'b1);
        chk("lineC ready (ack+swap)", int'(line_ready), 1);
        chk("lineC line_num", int'(line_num), 4);
        chk("lineC overrun", int'(overrun), 0);
        rd(2, 3);
        rd(10, 0);

        // Frame wrap
        for (int l = 5; l <= 143; l++) begin
            ack_pulse();
            fill_line(1, 0, 0, 1'b0);
        end
        chk("line 143 num", int'(line_num), 143);
        ack_pulse();
        fill_line(1, 0, 0, 1'b0);
        chk("line wrap num", int'(line_num), 0);
        ack_pulse();
        ppu_mode = M_VBLANK;
        tick();
        tick();
        chk("vbl frame_start low", int'(frame_start), 0);
        ppu_mode = M_SCAN;
        tick();
        chk("frame_start pulse", int'(frame_start), 1);
        tick();
        chk("frame_start one cycle", int'(frame_start), 0);
        ppu_mode = M_HBLANK;
        tick();
        fill_line(4, 2, 0, 1'b0);
        chk("post-vbl line_num", int'(line_num), 0);
        chk("post-vbl ready", int'(line_ready), 1);
        rd(0, 2);

        // Async reset mid-fill at wr_x=37
        ppu_mode = M_DRAW;
        tick();
        for (int i = 0; i < 37; i++) begin
            px_valid = 1'b1;
            px_in    = 2'd1;
            tick();
        end
        px_valid = 1'b0;
        chk("pre-reset ready", int'(line_ready), 1);
        chk("pre-reset rd_shade", int'(rd_shade), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst rd_shade", int'(rd_shade), 0);
        chk("async rst line_ready", int'(line_ready), 0);
        chk("async rst line_num", int'(line_num), 0);
        chk("async rst overrun", int'(overrun), 0);
        tick();
        rst = 1'b1;
        ppu_mode = M_HBLANK;
        tick();
        fill_line(5, 1, 0, 1'b0);
        chk("fresh line_ready", int'(line_ready), 1);
        chk("fresh line_num", int'(line_num), 0);
        rd(0, 1);
        rd(4, 1);
        rd(5, 0);

        tick();
        tick();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
